hamming_feed_seq: RTL and testbench

//  Upstream sequencer for the 5-bit/cycle Hamming-distance accumulator (1600 bits over 320 cycles).
//  - Accepts 40-bit garbler/evaluator words over valid/ready and slices them into 5-bit chunks, LSB first.
//  - Clears the accumulator at session start.
//  - Captures the accumulator's 11-bit sum on the cycle the last chunk is applied.
//  - Reports the result with a valid flag.

---
 rtl/hamming_feed_seq.sv | 133 +++++++++++++
 tb/tb_hamming_feed_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_feed_seq.sv
// Feeds 40-bit garbler/evaluator words to a 5-bit/cycle Hamming accumulator and captures the session sum.
// Optional threshold compare output is built when HAMMING_FEED_THRESH_EN is defined.
module hamming_feed_seq #(
    parameter int CHUNK_W      = 5,
    parameter int WORD_CHUNKS  = 8,
    parameter int TOTAL_CHUNKS = 320,
    parameter int CNT_W        = 11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHUNK_W*WORD_CHUNKS-1:0] g_word,
    input  logic [CHUNK_W*WORD_CHUNKS-1:0] e_word,
    output logic [CHUNK_W-1:0]             g_chunk,
    output logic [CHUNK_W-1:0]             e_chunk,
    output logic                           acc_rst,
    input  logic [CNT_W-1:0]               acc_o,
    output logic [CNT_W-1:0]               result,
    output logic                           result_valid,
    output logic                           busy
`ifdef HAMMING_FEED_THRESH_EN
    ,
    input  logic [CNT_W-1:0]               threshold,
    output logic                           match
`endif
);

    localparam int WORD_W = CHUNK_W * WORD_CHUNKS;
    localparam int WORDS  = TOTAL_CHUNKS / WORD_CHUNKS;

    localparam logic [8:0] LAST_CHUNK = 9'(TOTAL_CHUNKS - 1);
    localparam logic [5:0] WORDS_MAX  = 6'(WORDS);
    localparam logic [3:0] REM_FULL   = 4'(WORD_CHUNKS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] g_buf;
    logic [WORD_W-1:0] e_buf;
    logic [3:0]        rem;
    logic [8:0]        chunk_cnt;
    logic [5:0]        words_taken;

    logic chunk_live;
    logic take;
    logic last_chunk;

    assign chunk_live = (rem != 4'd0);
    assign in_ready   = (state == STREAM) && (words_taken < WORDS_MAX) && (rem <= 4'd1);
    assign take       = in_valid && in_ready;
    assign last_chunk = (state == STREAM) && chunk_live && (chunk_cnt == LAST_CHUNK);

    // An empty buffer drives equal zero chunks, which add nothing to the accumulator.
    assign g_chunk = chunk_live ? g_buf[CHUNK_W-1:0] : '0;
    assign e_chunk = chunk_live ? e_buf[CHUNK_W-1:0] : '0;

    assign acc_rst = rst | (state == CLEAR);
    assign busy    = (state == CLEAR) || (state == STREAM);

    // A word loaded while rem==1 replaces the shift of the chunk just consumed.
    always_ff @(posedge clk) begin
        if (take) begin
            g_buf <= g_word;
            e_buf <= e_word;
        end else if (chunk_live) begin
            g_buf <= g_buf >> CHUNK_W;
            e_buf <= e_buf >> CHUNK_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rem          <= 4'd0;
            chunk_cnt    <= 9'd0;
            words_taken  <= 6'd0;
            result       <= '0;
            result_valid <= 1'b0;
`ifdef HAMMING_FEED_THRESH_EN
            match        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= CLEAR;
                        rem          <= 4'd0;
                        chunk_cnt    <= 9'd0;
                        words_taken  <= 6'd0;
                        result_valid <= 1'b0;
`ifdef HAMMING_FEED_THRESH_EN
                        match        <= 1'b0;
`endif
                    end
                end
                CLEAR: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (take) begin
                        rem         <= REM_FULL;
                        words_taken <= words_taken + 6'd1;
                    end else if (chunk_live) begin
                        rem <= rem - 4'd1;
                    end
                    if (chunk_live) begin
                        chunk_cnt <= chunk_cnt + 9'd1;
                    end
                    // acc_o already includes the final chunk applied this cycle.
                    if (last_chunk) begin
                        result       <= acc_o;
                        result_valid <= 1'b1;
                        state        <= DONE;
`ifdef HAMMING_FEED_THRESH_EN
                        match        <= (acc_o <= threshold);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_feed_seq.sv
// Directed bench for hamming_feed_seq with a behavioural 5-bit/cycle Hamming accumulator attached.
module tb_hamming_feed_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] g_word;
    logic [39:0] e_word;
    logic [4:0]  g_chunk;
    logic [4:0]  e_chunk;
    logic        acc_rst;
    logic [10:0] acc_o;
    logic [10:0] result;
    logic        result_valid;
    logic        busy;
`ifdef HAMMING_FEED_THRESH_EN
    logic [10:0] threshold = 11'd0;
    logic        match;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hamming_feed_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .g_word       (g_word),
        .e_word       (e_word),
        .g_chunk      (g_chunk),
        .e_chunk      (e_chunk),
        .acc_rst      (acc_rst),
        .acc_o        (acc_o),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
`ifdef HAMMING_FEED_THRESH_EN
        ,
        .threshold    (threshold),
        .match        (match)
`endif
    );

    // Accumulator: registered running sum, combinational output includes the current chunk.
    logic [10:0] acc_q;
    always_comb acc_o = acc_q + 11'($countones(g_chunk ^ e_chunk));
    always_ff @(posedge clk) acc_q <= acc_rst ? 11'd0 : acc_o;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_clear_acc_rst"}, 32'(acc_rst), 32'd1);
        chk({tag, "_clear_busy"}, 32'(busy), 32'd1);
        chk({tag, "_clear_rv"}, 32'(result_valid), 32'd0);
        chk({tag, "_clear_ready"}, 32'(in_ready), 32'd0);
        step();
        chk({tag, "_stream_acc_rst"}, 32'(acc_rst), 32'd0);
        chk({tag, "_stream_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Streams one session; abort_at>0 returns after that many chunks, start_at>0 pulses start once.
    task automatic feed(input string tag, input logic [39:0] g, input logic [39:0] e,
                        input int period, input int abort_at, input int start_at,
                        input logic [10:0] exp_res, input bit exp_no_stall);
        int          rem = 0;
        int          chunks = 0;
        int          words = 0;
        int          stalls = 0;
        int          cyc = 0;
        bit          started = 0;
        logic        acc;
        logic [39:0] mg = '0;
        logic [39:0] me = '0;
        while (cyc < 2000) begin
            if (result_valid === 1'b1 || chunks == 320) break;
            if (abort_at > 0 && chunks == abort_at) break;
            in_valid = (cyc % period == 0);
            g_word   = g;
            e_word   = e;
            start    = 1'b0;
            if (start_at > 0 && chunks == start_at && !started) begin
                start   = 1'b1;
                started = 1;
            end
            chk({tag, "_g_chunk"}, 32'(g_chunk), 32'((rem > 0) ? mg[4:0] : 5'd0));
            chk({tag, "_e_chunk"}, 32'(e_chunk), 32'((rem > 0) ? me[4:0] : 5'd0));
            if (words > 0 && rem == 0) stalls++;
            acc = in_valid && in_ready;
            step();
            if (rem > 0) begin
                mg = mg >> 5;
                me = me >> 5;
                rem--;
                chunks++;
            end
            if (acc) begin
                mg = g;
                me = e;
                rem = 8;
                words++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (abort_at == 0) begin
            chk({tag, "_rv"}, 32'(result_valid), 32'd1);
            chk({tag, "_chunks_at_rv"}, 32'(chunks), 32'd320);
            chk({tag, "_words"}, 32'(words), 32'd40);
            chk({tag, "_result"}, 32'(result), 32'(exp_res));
            chk({tag, "_busy_done"}, 32'(busy), 32'd0);
            if (exp_no_stall) chk({tag, "_stalls"}, 32'(stalls), 32'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        g_word   = '0;
        e_word   = '0;
        step();
        chk("rst_acc_rst", 32'(acc_rst), 32'd1);
        step();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_g_chunk", 32'(g_chunk), 32'd0);
        chk("rst_e_chunk", 32'(e_chunk), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_acc_rst", 32'(acc_rst), 32'd0);

        // start together with rst: reset must win
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk("rst_start_busy", 32'(busy), 32'd0);
        chk("rst_start_acc_rst", 32'(acc_rst), 32'd0);

        do_start("eq");
        feed("eq", 40'h12_3456_789A, 40'h12_3456_789A, 1, 0, 0, 11'd0, 1);

        // no further words once 40 are taken, no extra chunks
        in_valid = 1'b1;
        #1;
        chk("done_ready", 32'(in_ready), 32'd0);
        chk("done_g_chunk", 32'(g_chunk), 32'd0);
        step();
        in_valid = 1'b0;
        chk("done_rv_hold", 32'(result_valid), 32'd1);
        chk("done_e_chunk", 32'(e_chunk), 32'd0);

        do_start("ones");
        feed("ones", 40'hFF_FFFF_FFFF, 40'h0, 1, 0, 0, 11'h640, 1);

        do_start("alt_p4");
        feed("alt_p4", 40'h55_5555_5555, 40'h0, 4, 0, 0, 11'd800, 0);

        do_start("alt_p5");
        feed("alt_p5", 40'h55_5555_5555, 40'h0, 5, 0, 0, 11'd800, 0);

        // abort mid-session with rst, then a full clean session
        do_start("abort");
        feed("abort", 40'hFF_FFFF_FFFF, 40'h0, 1, 150, 0, 11'd0, 0);
        rst = 1'b1;
        #1;
        chk("abort_acc_rst", 32'(acc_rst), 32'd1);
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_rv", 32'(result_valid), 32'd0);
        chk("abort_g_chunk", 32'(g_chunk), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_acc_rst_low", 32'(acc_rst), 32'd0);
        do_start("after_abort");
        feed("after_abort", 40'hFF_FFFF_FFFF, 40'h0, 1, 0, 0, 11'h640, 1);

        // start during STREAM is ignored
        do_start("mid_start");
        feed("mid_start", 40'hFF_FFFF_FFFF, 40'h0, 1, 0, 77, 11'h640, 1);

        // start in DONE: result_valid drops next cycle, result holds
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_rv", 32'(result_valid), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_acc_rst", 32'(acc_rst), 32'd1);
        chk("restart_result_hold", 32'(result), 32'h640);
        step();
        chk("restart_stream_busy", 32'(busy), 32'd1);
        chk("restart_stream_acc_rst", 32'(acc_rst), 32'd0);
        feed("restart", 40'h0, 40'h0, 1, 0, 0, 11'd0, 1);

`ifdef HAMMING_FEED_THRESH_EN
        threshold = 11'd799;
        do_start("thr799");
        feed("thr799", 40'h55_5555_5555, 40'h0, 1, 0, 0, 11'd800, 1);
        chk("thr799_match", 32'(match), 32'd0);
        threshold = 11'd800;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("thr_clear_match", 32'(match), 32'd0);
        step();
        feed("thr800", 40'h55_5555_5555, 40'h0, 1, 0, 0, 11'd800, 1);
        chk("thr800_match", 32'(match), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
